block_state_manager: RTL and testbench
======================================

Name: block_state_manager

Overview:
- Owns the 208-bit brick occupancy vector that the block drawer consumes to render bricks.
- Accepts ball-contact queries as pixel coordinates and maps each one to a brick index with a small sequential divider.
- Reports whether a brick was present at that point, clears the brick, and tracks how many bricks remain.
- Sits between the ball/collision logic (upstream) and the block drawer (downstream, via block_state).

Parameters:
BORDER_WIDTH, 8, pixel offset of the brick field from the top-left corner
BLOCK_WIDTH, 48, brick width in pixels
BLOCK_HEIGHT, 16, brick height in pixels; must be a power of two (row index = shift)
BLOCKS_PER_ROW, 13, bricks per row
NUM_ROWS, 16, brick rows
NUM_BLOCKS, 208, BLOCKS_PER_ROW*NUM_ROWS; width of block_state

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
level_load  input  1  single-cycle pulse: fill the brick field
query_valid  input  1  query request
query_ready  output  1  high when the block can accept a query
query_x  input  10  query pixel column (hpos space)
query_y  input  9  query pixel row (vpos space)
resp_valid  output  1  single-cycle response strobe
resp_hit  output  1  a brick was present at the query point and has been cleared
resp_idx  output  8  brick index row*BLOCKS_PER_ROW+col; 0 when outside the field
block_state  output  208  bit i set = brick i present; feeds the block drawer
blocks_remaining  output  8  count of set bits in block_state
all_cleared  output  1  single-cycle pulse when the last brick is cleared

Behaviour:
- Reset values (async on rst high): block_state=0, blocks_remaining=0, all_cleared=0, resp_valid=0, resp_hit=0, resp_idx=0, FSM=IDLE, query_ready=1.
- FSM states:
  - IDLE: query_ready=1.
  - DIVIDE, LOOKUP, RESP: query_ready=0.
- Query acceptance: a query is accepted at edge E0 where query_valid && query_ready && !level_load. query_x and query_y are latched at that edge.
- In-field test: BORDER_WIDTH <= x < BORDER_WIDTH+BLOCKS_PER_ROW*BLOCK_WIDTH (632) and BORDER_WIDTH <= y < BORDER_WIDTH+NUM_ROWS*BLOCK_HEIGHT (264).
- Outside the field: IDLE->RESP at E0. resp_valid=1, resp_hit=0, resp_idx=0 in the cycle after E0. No state change.
- Inside the field at E0: go to DIVIDE and set:
  - x_rel = x-BORDER_WIDTH (10 bits)
  - row = (y-BORDER_WIDTH)>>log2(BLOCK_HEIGHT) (4 bits)
  - col = 0 (4 bits)
- DIVIDE, each edge:
  - if x_rel >= BLOCK_WIDTH: x_rel -= BLOCK_WIDTH, col += 1, stay in DIVIDE;
  - else go to LOOKUP.
  - This takes col+1 edges (E1..E(col+1)).
- LOOKUP: idx = row*13+col, computed combinationally with 8-bit arithmetic (max 207). At edge E(col+2):
  - resp_idx=idx, resp_hit=block_state[idx];
  - if the bit is set: clear it and decrement blocks_remaining on the same edge;
  - go to RESP.
- RESP: resp_valid is high for exactly one cycle. Next edge: IDLE, resp_valid=0. resp_hit and resp_idx hold until the next response.
- Latency from acceptance edge E0:
  - in-field: resp_valid high in the cycle after E(col+2), i.e. 3 to 15 cycles;
  - outside the field: 1 cycle.
- all_cleared: registered one-cycle pulse on the edge after blocks_remaining goes 1->0. Never pulses on reset or on level_load.
- level_load has highest priority and is honoured in any state:
  - block_state <= all ones, blocks_remaining <= NUM_BLOCKS, FSM <= IDLE;
  - an in-flight query is abandoned with no resp_valid, and resp_valid is forced to 0;
  - a query_valid in the same cycle as level_load is not accepted.
- Hitting an already-empty brick: resp_hit=0, no counter change, no all_cleared pulse.
- block_state changes only at LOOKUP edges or on level_load, so it is stable during a frame except for single-bit clears.

Test Plan:
- Reset: assert rst mid-DIVIDE -> all outputs at reset values immediately, query_ready=1; then level_load pulse -> block_state all ones, blocks_remaining=208.
- Query (8,8) -> resp_idx=0, resp_hit=1, resp_valid in the 3rd cycle after acceptance, block_state[0]=0, blocks_remaining=207; repeat (8,8) -> resp_hit=0, remaining stays 207.
- Query (631,263) -> col=12, row=15, resp_idx=207, resp_valid 15 cycles after acceptance; query (56,24) -> resp_idx=14.
- Query (4,100) and (640,20) -> resp_hit=0, resp_idx=0, resp_valid 1 cycle after acceptance, block_state unchanged.
- Clear all 208 bricks via queries -> all_cleared pulses exactly once, one cycle after the final LOOKUP edge, blocks_remaining=0.
- level_load asserted during DIVIDE and simultaneously with query_valid -> no resp_valid, query not accepted, block_state all ones, remaining=208.

Source files
------------

// File: rtl/block_state_manager.sv
// Brick occupancy owner for the breakout field: maps ball-contact pixel queries
// to brick indices with a subtract-based divider, clears hit bricks and counts survivors.
module block_state_manager #(
  parameter int BORDER_WIDTH   = 8,
  parameter int BLOCK_WIDTH    = 48,
  parameter int BLOCK_HEIGHT   = 16,
  parameter int BLOCKS_PER_ROW = 13,
  parameter int NUM_ROWS       = 16,
  parameter int NUM_BLOCKS     = BLOCKS_PER_ROW * NUM_ROWS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  level_load,
  input  logic                  query_valid,
  output logic                  query_ready,
  input  logic [9:0]            query_x,
  input  logic [8:0]            query_y,
  output logic                  resp_valid,
  output logic                  resp_hit,
  output logic [7:0]            resp_idx,
  output logic [NUM_BLOCKS-1:0] block_state,
  output logic [7:0]            blocks_remaining,
  output logic                  all_cleared
);

  localparam int ROW_SHIFT = $clog2(BLOCK_HEIGHT);

  localparam logic [9:0] X_LO = 10'(BORDER_WIDTH);
  localparam logic [9:0] X_HI = 10'(BORDER_WIDTH + BLOCKS_PER_ROW * BLOCK_WIDTH);
  localparam logic [8:0] Y_LO = 9'(BORDER_WIDTH);
  localparam logic [8:0] Y_HI = 9'(BORDER_WIDTH + NUM_ROWS * BLOCK_HEIGHT);
  localparam logic [9:0] BW   = 10'(BLOCK_WIDTH);
  localparam logic [7:0] BPR  = 8'(BLOCKS_PER_ROW);
  localparam logic [7:0] FULL = 8'(NUM_BLOCKS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    LOOKUP = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t state_reg, state_next;

  logic [9:0]            x_rel_reg, x_rel_next;
  logic [3:0]            row_reg, row_next;
  logic [3:0]            col_reg, col_next;
  logic                  resp_valid_reg, resp_valid_next;
  logic                  resp_hit_reg, resp_hit_next;
  logic [7:0]            resp_idx_reg, resp_idx_next;
  logic [7:0]            remaining_reg, remaining_next;
  logic                  last_clear_reg, last_clear_next;
  logic                  all_cleared_reg, all_cleared_next;
  logic [NUM_BLOCKS-1:0] block_state_reg, block_state_next;

  logic       accept;
  logic       in_field;
  logic [8:0] y_off;
  logic [7:0] lookup_idx;
  logic       lookup_bit;
  logic       clear_en;

  assign query_ready = (state_reg == IDLE);
  assign accept      = query_valid && query_ready && !level_load;
  assign in_field    = (query_x >= X_LO) && (query_x < X_HI) &&
                       (query_y >= Y_LO) && (query_y < Y_HI);
  assign y_off       = query_y - Y_LO;
  assign lookup_idx  = 8'(row_reg) * BPR + 8'(col_reg);
  assign lookup_bit  = block_state_reg[lookup_idx];

  always_comb begin
    state_next       = state_reg;
    x_rel_next       = x_rel_reg;
    row_next         = row_reg;
    col_next         = col_reg;
    resp_valid_next  = 1'b0;
    resp_hit_next    = resp_hit_reg;
    resp_idx_next    = resp_idx_reg;
    remaining_next   = remaining_reg;
    clear_en         = 1'b0;
    // The "last brick gone" flag lives one cycle so the pulse trails the clear.
    last_clear_next  = 1'b0;
    all_cleared_next = last_clear_reg;

    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (in_field) begin
            state_next = DIVIDE;
            x_rel_next = query_x - X_LO;
            row_next   = 4'(y_off >> ROW_SHIFT);
            col_next   = 4'd0;
          end else begin
            state_next      = RESP;
            resp_valid_next = 1'b1;
            resp_hit_next   = 1'b0;
            resp_idx_next   = 8'd0;
          end
        end
      end
      DIVIDE: begin
        if (x_rel_reg >= BW) begin
          x_rel_next = x_rel_reg - BW;
          col_next   = col_reg + 4'd1;
        end else begin
          state_next = LOOKUP;
        end
      end
      LOOKUP: begin
        state_next      = RESP;
        resp_valid_next = 1'b1;
        resp_idx_next   = lookup_idx;
        resp_hit_next   = lookup_bit;
        if (lookup_bit) begin
          clear_en        = 1'b1;
          remaining_next  = remaining_reg - 8'd1;
          last_clear_next = (remaining_reg == 8'd1);
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // A refill overrides everything, including an in-flight query.
    if (level_load) begin
      state_next       = IDLE;
      resp_valid_next  = 1'b0;
      remaining_next   = FULL;
      clear_en         = 1'b0;
      last_clear_next  = 1'b0;
      all_cleared_next = 1'b0;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BLOCKS; gi++) begin : g_brick
      assign block_state_next[gi] = level_load |
        (block_state_reg[gi] & ~(clear_en && (lookup_idx == 8'(gi))));
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_rel_reg       <= '0;
      row_reg         <= '0;
      col_reg         <= '0;
      resp_valid_reg  <= 1'b0;
      resp_hit_reg    <= 1'b0;
      resp_idx_reg    <= '0;
      remaining_reg   <= '0;
      last_clear_reg  <= 1'b0;
      all_cleared_reg <= 1'b0;
      block_state_reg <= '0;
    end else begin
      x_rel_reg       <= x_rel_next;
      row_reg         <= row_next;
      col_reg         <= col_next;
      resp_valid_reg  <= resp_valid_next;
      resp_hit_reg    <= resp_hit_next;
      resp_idx_reg    <= resp_idx_next;
      remaining_reg   <= remaining_next;
      last_clear_reg  <= last_clear_next;
      all_cleared_reg <= all_cleared_next;
      block_state_reg <= block_state_next;
    end
  end

  assign resp_valid       = resp_valid_reg;
  assign resp_hit         = resp_hit_reg;
  assign resp_idx         = resp_idx_reg;
  assign block_state      = block_state_reg;
  assign blocks_remaining = remaining_reg;
  assign all_cleared      = all_cleared_reg;

endmodule

// File: tb/tb_block_state_manager.sv
// Directed bench for block_state_manager: pixel queries with hand-computed
// brick indices, latencies, counter values and refill/reset behaviour.
module tb_block_state_manager;

  logic         clk;
  logic         rst;
  logic         level_load;
  logic         query_valid;
  logic         query_ready;
  logic [9:0]   query_x;
  logic [8:0]   query_y;
  logic         resp_valid;
  logic         resp_hit;
  logic [7:0]   resp_idx;
  logic [207:0] block_state;
  logic [7:0]   blocks_remaining;
  logic         all_cleared;

  int checks   = 0;
  int failures = 0;
  int ac_count = 0;

  localparam logic [207:0] ALL_ONES = {208{1'b1}};

  block_state_manager dut (
    .clk              (clk),
    .rst              (rst),
    .level_load       (level_load),
    .query_valid      (query_valid),
    .query_ready      (query_ready),
    .query_x          (query_x),
    .query_y          (query_y),
    .resp_valid       (resp_valid),
    .resp_hit         (resp_hit),
    .resp_idx         (resp_idx),
    .block_state      (block_state),
    .blocks_remaining (blocks_remaining),
    .all_cleared      (all_cleared)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (all_cleared) ac_count++;

  task automatic check(input string tag, input logic [207:0] got, input logic [207:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Issue one query, wait for its response, then step past the RESP cycle.
  task automatic run_query(input logic [9:0] x, input logic [8:0] y,
                           output int lat, output logic hit, output logic [7:0] idx);
    @(negedge clk);
    query_valid = 1'b1;
    query_x     = x;
    query_y     = y;
    @(posedge clk);
    #1;
    query_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!resp_valid) check("resp_timeout", 208'(0), 208'(1));
    hit = resp_hit;
    idx = resp_idx;
    @(posedge clk);
    #1;
    check("resp_one_cycle", 208'(resp_valid), 208'(0));
  endtask

  task automatic pulse_load();
    @(negedge clk);
    level_load = 1'b1;
    @(negedge clk);
    level_load = 1'b0;
  endtask

  int           lat;
  logic         hit;
  logic [7:0]   idx;
  logic [207:0] saved;
  int           rv_seen;

  initial begin
    rst         = 1'b1;
    level_load  = 1'b0;
    query_valid = 1'b0;
    query_x     = '0;
    query_y     = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", block_state, 208'(0));
    check("rst_remaining", 208'(blocks_remaining), 208'(0));
    check("rst_ready", 208'(query_ready), 208'(1));
    @(negedge clk);
    rst = 1'b0;

    pulse_load();
    run_query(10'd56, 9'd24, lat, hit, idx);
    check("pre_idx", 208'(idx), 208'(14));

    // Reset in the middle of a divide
    @(negedge clk);
    query_valid = 1'b1; query_x = 10'd631; query_y = 9'd263;
    @(posedge clk); #1; query_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_state", block_state, 208'(0));
    check("midrst_remaining", 208'(blocks_remaining), 208'(0));
    check("midrst_ready", 208'(query_ready), 208'(1));
    check("midrst_valid", 208'(resp_valid), 208'(0));
    check("midrst_hit", 208'(resp_hit), 208'(0));
    check("midrst_idx", 208'(resp_idx), 208'(0));
    check("midrst_allclr", 208'(all_cleared), 208'(0));
    @(negedge clk);
    rst = 1'b0;

    pulse_load();
    check("load_state", block_state, ALL_ONES);
    check("load_remaining", 208'(blocks_remaining), 208'(208));

    run_query(10'd8, 9'd8, lat, hit, idx);
    check("q88_lat", 208'(lat), 208'(3));
    check("q88_hit", 208'(hit), 208'(1));
    check("q88_idx", 208'(idx), 208'(0));
    check("q88_bit0", 208'(block_state[0]), 208'(0));
    check("q88_remaining", 208'(blocks_remaining), 208'(207));
    run_query(10'd8, 9'd8, lat, hit, idx);
    check("q88b_hit", 208'(hit), 208'(0));
    check("q88b_remaining", 208'(blocks_remaining), 208'(207));

    run_query(10'd631, 9'd263, lat, hit, idx);
    check("qmax_lat", 208'(lat), 208'(15));
    check("qmax_idx", 208'(idx), 208'(207));
    check("qmax_hit", 208'(hit), 208'(1));
    run_query(10'd56, 9'd24, lat, hit, idx);
    check("q56_lat", 208'(lat), 208'(4));
    check("q56_idx", 208'(idx), 208'(14));
    check("q56_remaining", 208'(blocks_remaining), 208'(205));

    saved = block_state;
    run_query(10'd4, 9'd100, lat, hit, idx);
    check("qleft_lat", 208'(lat), 208'(1));
    check("qleft_hit", 208'(hit), 208'(0));
    check("qleft_idx", 208'(idx), 208'(0));
    run_query(10'd640, 9'd20, lat, hit, idx);
    check("qright_lat", 208'(lat), 208'(1));
    check("qright_idx", 208'(idx), 208'(0));
    run_query(10'd632, 9'd20, lat, hit, idx);
    check("qxedge_lat", 208'(lat), 208'(1));
    run_query(10'd100, 9'd264, lat, hit, idx);
    check("qyedge_lat", 208'(lat), 208'(1));
    check("qout_state", block_state, saved);
    check("qout_remaining", 208'(blocks_remaining), 208'(205));

    // Clear every brick; bricks 0, 14 and 207 are already gone
    ac_count = 0;
    for (int r = 0; r < 16; r++) begin
      for (int c = 0; c < 13; c++) begin
        logic exp_hit;
        exp_hit = !((r == 0 && c == 0) || (r == 1 && c == 1) || (r == 15 && c == 12));
        run_query(10'(8 + 48 * c + (c * 7) % 48), 9'(8 + 16 * r + r % 16), lat, hit, idx);
        check($sformatf("sweep_idx_r%0d_c%0d", r, c), 208'(idx), 208'(r * 13 + c));
        check($sformatf("sweep_hit_r%0d_c%0d", r, c), 208'(hit), 208'(exp_hit));
        check($sformatf("sweep_lat_r%0d_c%0d", r, c), 208'(lat), 208'(c + 3));
        if (r == 15 && c == 11) check("final_allclr_pulse", 208'(all_cleared), 208'(1));
      end
    end
    check("sweep_remaining", 208'(blocks_remaining), 208'(0));
    check("sweep_state", block_state, 208'(0));
    check("sweep_ac_count", 208'(ac_count), 208'(1));
    run_query(10'd8, 9'd8, lat, hit, idx);
    check("empty_hit", 208'(hit), 208'(0));
    check("empty_ac_count", 208'(ac_count), 208'(1));

    // Refill during a divide abandons the query
    @(negedge clk);
    query_valid = 1'b1; query_x = 10'd631; query_y = 9'd263;
    @(negedge clk);
    query_valid = 1'b0;
    @(negedge clk);
    level_load = 1'b1;
    @(negedge clk);
    level_load = 1'b0;
    rv_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (resp_valid) rv_seen++;
    end
    check("abandon_no_resp", 208'(rv_seen), 208'(0));
    check("abandon_state", block_state, ALL_ONES);
    check("abandon_remaining", 208'(blocks_remaining), 208'(208));
    check("abandon_ac_count", 208'(ac_count), 208'(1));

    // Refill together with a query: query is not taken
    @(negedge clk);
    query_valid = 1'b1; level_load = 1'b1; query_x = 10'd8; query_y = 9'd8;
    @(negedge clk);
    query_valid = 1'b0; level_load = 1'b0;
    check("simul_ready", 208'(query_ready), 208'(1));
    rv_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (resp_valid) rv_seen++;
    end
    check("simul_no_resp", 208'(rv_seen), 208'(0));
    check("simul_state", block_state, ALL_ONES);
    check("simul_remaining", 208'(blocks_remaining), 208'(208));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
